// File: rtl/range_sched_pkg.sv
// range_sched_pkg: shared state encoding, error codes and range width for range_sched.
package range_sched_pkg;
  localparam int RW = 16;
  typedef enum logic [1:0] {COLLECT, START, WAIT} state_t;
  localparam logic [1:0] ERR_RANGE = 2'b00;
  localparam logic [1:0] ERR_CTMO  = 2'b01;
  localparam logic [1:0] ERR_WRONG = 2'b10;
  localparam logic [1:0] ERR_STMO  = 2'b11;
endpackage

// File: rtl/rs_timer.sv
// rs_timer: clearable up-counter; tc_o flags the enabled cycle whose increment reaches TC.
module rs_timer #(
  parameter int W  = 8,
  parameter int TC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign tc_o = en_i && cnt_q == W'(TC - 1);
endmodule

// File: rtl/range_sched.sv
// range_sched: collects four anchor ranges, launches the 2D solver and handles timeouts.
// Define RANGE_SCHED_FILTER_EN to average each new range with the previous round's value.
module range_sched
  import range_sched_pkg::*;
#(
  parameter int           TIMEOUT_CYC = 1000,
  parameter int           SOLVE_TMO   = 64,
  parameter logic [RW-1:0] MAX_RANGE  = 16'd20000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] r_in,
  input  logic [1:0]    r_id,
  input  logic          r_valid,
  output logic          r_ready,
  output logic [RW-1:0] r0,
  output logic [RW-1:0] r1,
  output logic [RW-1:0] r2,
  output logic [RW-1:0] r3,
  output logic          solve_start,
  input  logic          solve_done,
  input  logic [RW-1:0] x_in,
  input  logic [RW-1:0] y_in,
  input  logic          wrong_in,
  output logic [RW-1:0] x_out,
  output logic [RW-1:0] y_out,
  output logic          pos_valid,
  output logic          err,
  output logic [1:0]    err_code
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SOLVE_TMO + 1);
  state_t                 state_q;
  logic [3:0]             mask_q;
  logic [3:0][RW-1:0]     r_q;
  logic [RW-1:0]          x_q, y_q, r_new;
  logic                   solve_start_q, pos_valid_q, err_q;
  logic [1:0]             err_code_q;
  logic                   acc, good, done_set, ctmo, coll_en, coll_clr, coll_tc, solve_tc;
  logic [3:0]             mask_n;
  assign acc      = r_valid && state_q == COLLECT;
  assign good     = acc && r_in <= MAX_RANGE;
  assign mask_n   = good ? mask_q | (4'b1 << r_id) : mask_q;
  assign done_set = state_q == COLLECT && mask_n == 4'hF;
  // the timer includes the cycle of the first good sample of a round
  assign coll_en  = state_q == COLLECT && mask_n != 4'h0;
  assign ctmo     = coll_tc && !done_set;
  assign coll_clr = state_q != COLLECT || ctmo || done_set;
  rs_timer #(.W(CW), .TC(TIMEOUT_CYC)) u_coll_tmr (
    .clk(clk), .reset(reset), .clr_i(coll_clr), .en_i(coll_en), .tc_o(coll_tc)
  );
  rs_timer #(.W(SW), .TC(SOLVE_TMO)) u_solve_tmr (
    .clk(clk), .reset(reset), .clr_i(state_q != WAIT), .en_i(state_q == WAIT), .tc_o(solve_tc)
  );
`ifdef RANGE_SCHED_FILTER_EN
  logic [3:0]  hist_q;
  logic [RW:0] sum;
  assign sum   = {1'b0, r_q[r_id]} + {1'b0, r_in};
  assign r_new = hist_q[r_id] ? RW'(sum >> 1) : r_in;
  // every anchor holds a value once a round completes; a collect timeout forgets them
  always_ff @(posedge clk or posedge reset)
    if (reset) hist_q <= '0;
    else if (ctmo) hist_q <= '0;
    else if (done_set) hist_q <= 4'hF;
`else
  assign r_new = r_in;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= COLLECT;
      mask_q        <= '0;
      r_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      solve_start_q <= 1'b0;
      pos_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_RANGE;
    end else begin
      solve_start_q <= 1'b0;
      pos_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (good) r_q[r_id] <= r_new;
          if (done_set) begin
            state_q       <= START;
            solve_start_q <= 1'b1;
            mask_q        <= mask_n;
          end else if (ctmo) begin
            mask_q     <= '0;
            err_q      <= 1'b1;
            err_code_q <= ERR_CTMO;
          end else begin
            mask_q <= mask_n;
            if (acc && !good) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_RANGE;
            end
          end
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (solve_done || solve_tc) begin
            state_q <= COLLECT;
            mask_q  <= '0;
          end
          if (solve_done && !wrong_in) begin
            x_q         <= x_in;
            y_q         <= y_in;
            pos_valid_q <= 1'b1;
          end else if (solve_done || solve_tc) begin
            err_q      <= 1'b1;
            err_code_q <= solve_done ? ERR_WRONG : ERR_STMO;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  assign r_ready     = state_q == COLLECT;
  assign {r3, r2, r1, r0} = r_q;
  assign solve_start = solve_start_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign pos_valid   = pos_valid_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
endmodule

// File: tb/tb_range_sched.sv
// tb_range_sched: directed checks of collection, solver handshake, timeouts and reset.
module tb_range_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] r_in = '0;
  logic [1:0]  r_id = '0;
  logic        r_valid = 1'b0;
  logic        r_ready;
  logic [15:0] r0, r1, r2, r3;
  logic        solve_start;
  logic        solve_done = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        wrong_in = 1'b0;
  logic [15:0] x_out, y_out;
  logic        pos_valid, err;
  logic [1:0]  err_code;
  int          total = 0;
  int          bad = 0;
`ifdef RANGE_SCHED_FILTER_EN
  localparam int R0B = 150;
`else
  localparam int R0B = 200;
`endif
  always #5 clk = ~clk;
  range_sched #(.TIMEOUT_CYC(20), .SOLVE_TMO(8)) dut (
    .clk(clk), .reset(reset), .r_in(r_in), .r_id(r_id), .r_valid(r_valid), .r_ready(r_ready),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .solve_start(solve_start), .solve_done(solve_done),
    .x_in(x_in), .y_in(y_in), .wrong_in(wrong_in), .x_out(x_out), .y_out(y_out),
    .pos_valid(pos_valid), .err(err), .err_code(err_code)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] id, input logic [15:0] v);
    r_valid = 1'b1;
    r_id    = id;
    r_in    = v;
    tick();
    r_valid = 1'b0;
  endtask
  initial begin
    int n;
    logic saw;
    tick();
    tick();
    chk("rst_ready", r_ready, 1);
    chk("rst_r0", r0, 0);
    chk("rst_x", x_out, 0);
    chk("rst_ss", solve_start, 0);
    chk("rst_pv", pos_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    reset = 1'b0;
    tick();
    send(0, 100);
    send(1, 200);
    send(2, 300);
    chk("a_ss_early", solve_start, 0);
    chk("a_ready", r_ready, 1);
    send(3, 400);
    chk("a_ss", solve_start, 1);
    chk("a_ready_start", r_ready, 0);
    chk("a_r0", r0, 100);
    chk("a_r1", r1, 200);
    chk("a_r2", r2, 300);
    chk("a_r3", r3, 400);
    tick();
    chk("a_ss_pulse", solve_start, 0);
    solve_done = 1'b1;
    x_in = 1000;
    y_in = 1000;
    tick();
    solve_done = 1'b0;
    chk("a_pv", pos_valid, 1);
    chk("a_x", x_out, 1000);
    chk("a_y", y_out, 1000);
    chk("a_ready_back", r_ready, 1);
    tick();
    chk("a_pv_pulse", pos_valid, 0);
    send(2, 30000);
    chk("b_rej_err", err, 1);
    chk("b_rej_code", err_code, 0);
    send(2, 20001);
    chk("b_max1_err", err, 1);
    send(0, 200);
    chk("b_good_err", err, 0);
    send(1, 200);
    send(3, 400);
    chk("b_mask2_clear", solve_start, 0);
    send(2, 300);
    chk("b_ss", solve_start, 1);
    chk("b_r0", r0, R0B);
    chk("b_r2", r2, 300);
    tick();
    solve_done = 1'b1;
    wrong_in   = 1'b1;
    x_in = 5;
    y_in = 6;
    tick();
    solve_done = 1'b0;
    wrong_in   = 1'b0;
    chk("b_wrong_err", err, 1);
    chk("b_wrong_code", err_code, 2);
    chk("b_wrong_pv", pos_valid, 0);
    chk("b_wrong_x", x_out, 1000);
    chk("b_ready", r_ready, 1);
    send(0, 10);
    send(1, 20);
    send(2, 30);
    n = 3;
    saw = 1'b0;
    while (!err && n < 40) begin
      tick();
      n++;
      if (solve_start) saw = 1'b1;
    end
    chk("c_tmo_cycle", n, 20);
    chk("c_tmo_code", err_code, 1);
    chk("c_no_ss", saw, 0);
    send(3, 20000);
    chk("c_max_ok", err, 0);
    chk("c_mask_cleared", solve_start, 0);
    send(0, 500);
    send(1, 600);
    send(2, 700);
    chk("d_ss", solve_start, 1);
    chk("d_r0_raw", r0, 500);
    chk("d_r3_max", r3, 20000);
    r_valid = 1'b1;
    r_id    = 0;
    r_in    = 999;
    tick();
    r_valid = 1'b0;
    chk("d_r0_stable", r0, 500);
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    chk("d_stmo_cycle", n, 8);
    chk("d_stmo_code", err_code, 3);
    chk("d_ready", r_ready, 1);
    send(0, 1);
    send(1, 2);
    send(2, 3);
    send(3, 4);
    chk("e_ss", solve_start, 1);
    tick();
    chk("e_wait", r_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("e_rst_ready", r_ready, 1);
    chk("e_rst_r0", r0, 0);
    chk("e_rst_r3", r3, 0);
    chk("e_rst_x", x_out, 0);
    chk("e_rst_y", y_out, 0);
    chk("e_rst_code", err_code, 0);
    chk("e_rst_err", err, 0);
    chk("e_rst_ss", solve_start, 0);
    chk("e_rst_pv", pos_valid, 0);
    reset = 1'b0;
    solve_done = 1'b1;
    x_in = 7;
    y_in = 7;
    tick();
    solve_done = 1'b0;
    chk("e_stale_pv", pos_valid, 0);
    chk("e_stale_err", err, 0);
    chk("e_stale_x", x_out, 0);
    chk("e_stale_ready", r_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
